// File: rtl/sec_reg_pkg.sv
// Shared types and constants for the permission-checked register responder.
package sec_reg_pkg;

  localparam int unsigned DEF_DW    = 8;
  localparam int unsigned DEF_NREGS = 3;
  localparam int unsigned ADDR_W    = 2;
  localparam int unsigned CNT_W     = 8;

  localparam logic [CNT_W-1:0] VIOL_MAX = CNT_W'(255);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    RESP  = 2'd2
  } state_t;

  // Request header captured on acceptance; write data is held separately since its width is a parameter.
  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
  } req_hdr_t;

  function automatic logic addr_ok(input logic [ADDR_W-1:0] addr, input int unsigned nregs);
    return 32'(addr) < nregs;
  endfunction

endpackage

// File: rtl/perm_latch.sv
// Read/write permission latch with a sticky lock that freezes the permissions until reset.
module perm_latch (
  input  logic clk,
  input  logic rst_n,
  input  logic cfg_re,
  input  logic cfg_we,
  input  logic cfg_lock,
  output logic re_q,
  output logic we_q,
  output logic locked
);

  // The cycle that samples cfg_lock still loads permissions; the freeze starts one cycle later.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      re_q   <= 1'b0;
      we_q   <= 1'b0;
      locked <= 1'b0;
    end else if (!locked) begin
      re_q <= cfg_re;
      we_q <= cfg_we;
      if (cfg_lock) begin
        locked <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/sec_reg_resp.sv
// Small register file behind a request/response handshake, gated by latched read/write permissions.
module sec_reg_resp
  import sec_reg_pkg::*;
#(
  parameter int unsigned NREGS = DEF_NREGS,
  parameter int unsigned DW    = DEF_DW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_re,
  input  logic              cfg_we,
  input  logic              cfg_lock,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DW-1:0]     req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DW-1:0]     rsp_rdata,
  output logic              rsp_err,
  output logic              locked,
  output logic [CNT_W-1:0]  viol_cnt
);

  state_t           state_q;
  state_t           state_d;
  req_hdr_t         hdr_q;
  logic [DW-1:0]    wdata_q;
  logic [DW-1:0]    regs [NREGS];
  logic             re_q;
  logic             we_q;
  logic             accept_c;
  logic             check_c;
  logic             allow_c;
  logic [DW-1:0]    rd_sel_c;

  perm_latch u_perm_latch (
    .clk      (clk),
    .rst_n    (rst_n),
    .cfg_re   (cfg_re),
    .cfg_we   (cfg_we),
    .cfg_lock (cfg_lock),
    .re_q     (re_q),
    .we_q     (we_q),
    .locked   (locked)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    accept_c = 1'b0;
    check_c  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          accept_c = 1'b1;
          state_d  = CHECK;
        end
      end
      CHECK: begin
        check_c = 1'b1;
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Access decision uses the permissions as latched in the CHECK cycle itself.
  always_comb begin
    allow_c = addr_ok(hdr_q.addr, NREGS) && (hdr_q.write ? we_q : re_q);
  end

  always_comb begin
    rd_sel_c = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (hdr_q.addr == ADDR_W'(i)) begin
        rd_sel_c = regs[i];
      end
    end
  end

  // Handshake flags track the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      viol_cnt  <= '0;
      hdr_q     <= '0;
      wdata_q   <= '0;
    end else begin
      req_ready <= (state_d == IDLE);
      rsp_valid <= (state_d == RESP);
      if (accept_c) begin
        hdr_q.write <= req_write;
        hdr_q.addr  <= req_addr;
        wdata_q     <= req_wdata;
      end
      if (check_c) begin
        rsp_err   <= !allow_c;
        rsp_rdata <= (allow_c && !hdr_q.write) ? rd_sel_c : '0;
        if (!allow_c && (viol_cnt != VIOL_MAX)) begin
          viol_cnt <= viol_cnt + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NREGS; i++) begin
      if (!rst_n) begin
        regs[i] <= '0;
      end else if (check_c && allow_c && hdr_q.write && (hdr_q.addr == ADDR_W'(i))) begin
        regs[i] <= wdata_q;
      end
    end
  end

endmodule

// File: tb/tb_sec_reg_resp.sv
// Directed self-checking bench for sec_reg_resp.
module tb_sec_reg_resp;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cfg_re, cfg_we, cfg_lock;
  logic       req_valid, req_ready, req_write;
  logic [1:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid, rsp_ready, rsp_err, locked;
  logic [7:0] rsp_rdata, viol_cnt;

  int tests = 0;
  int fails = 0;

  logic [7:0] rd;
  logic       er;
  int         lat;

  sec_reg_resp dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_re    (cfg_re),
    .cfg_we    (cfg_we),
    .cfg_lock  (cfg_lock),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .locked    (locked),
    .viol_cnt  (viol_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full transaction; flip_we raises cfg_we while the request sits in CHECK.
  task automatic access(input logic wr, input logic [1:0] a, input logic [7:0] wd,
                        input logic flip_we, output logic [7:0] rdo, output logic ero,
                        output int lato);
    int cyc;
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_wdata = wd;
    rsp_ready = 1'b0;
    tick();
    req_valid = 1'b0;
    if (flip_we) cfg_we = 1'b1;
    cyc = 1;
    while (!rsp_valid && cyc < 10) begin
      tick();
      cyc++;
    end
    rdo  = rsp_rdata;
    ero  = rsp_err;
    lato = cyc;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; cfg_re = 1'b0; cfg_we = 1'b0; cfg_lock = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = 2'd0; req_wdata = 8'd0; rsp_ready = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_err",   32'(rsp_err),   32'd0);
    check("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
    check("rst_locked",    32'(locked),    32'd0);
    check("rst_viol",      32'(viol_cnt),  32'd0);

    // Write then read back addr1
    cfg_we = 1'b1;
    access(1'b1, 2'd1, 8'hA5, 1'b0, rd, er, lat);
    check("wr1_err",   32'(er),  32'd0);
    check("wr1_rdata", 32'(rd),  32'd0);
    check("wr1_lat",   32'(lat), 32'd2);
    cfg_re = 1'b1;
    access(1'b0, 2'd1, 8'h00, 1'b0, rd, er, lat);
    check("rd1_rdata", 32'(rd),  32'hA5);
    check("rd1_err",   32'(er),  32'd0);
    check("rd1_lat",   32'(lat), 32'd2);

    // Permission raised during CHECK comes too late
    cfg_we = 1'b0;
    tick();
    access(1'b1, 2'd2, 8'h77, 1'b1, rd, er, lat);
    check("late_we_err",  32'(er),       32'd1);
    check("late_we_viol", 32'(viol_cnt), 32'd1);
    access(1'b0, 2'd2, 8'h00, 1'b0, rd, er, lat);
    check("late_we_addr2", 32'(rd), 32'd0);
    check("late_we_rderr", 32'(er), 32'd0);

    // Out-of-range read
    access(1'b0, 2'd3, 8'h00, 1'b0, rd, er, lat);
    check("oor_err",   32'(er),       32'd1);
    check("oor_rdata", 32'(rd),       32'd0);
    check("oor_viol",  32'(viol_cnt), 32'd2);

    // Response held under back-pressure; a new request must not be taken
    req_valid = 1'b1; req_write = 1'b0; req_addr = 2'd1; req_wdata = 8'h00; rsp_ready = 1'b0;
    tick();
    req_valid = 1'b0;
    tick();
    for (int k = 0; k < 5; k++) begin
      check("bp_valid", 32'(rsp_valid), 32'd1);
      check("bp_rdata", 32'(rsp_rdata), 32'hA5);
      check("bp_err",   32'(rsp_err),   32'd0);
      check("bp_ready", 32'(req_ready), 32'd0);
      req_valid = 1'b1; req_write = 1'b1; req_addr = 2'd0; req_wdata = 8'h11;
      tick();
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("bp_done_valid", 32'(rsp_valid), 32'd0);
    check("bp_done_ready", 32'(req_ready), 32'd1);
    access(1'b0, 2'd0, 8'h00, 1'b0, rd, er, lat);
    check("bp_addr0", 32'(rd), 32'd0);

    // Lock with write permission off, then try to enable it
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("rst2_viol",   32'(viol_cnt), 32'd0);
    check("rst2_locked", 32'(locked),   32'd0);
    cfg_re = 1'b1; cfg_we = 1'b0; cfg_lock = 1'b1;
    tick();
    cfg_lock = 1'b0; cfg_we = 1'b1;
    check("lock_set", 32'(locked), 32'd1);
    tick();
    access(1'b1, 2'd0, 8'h3C, 1'b0, rd, er, lat);
    check("lock_wr_err", 32'(er),       32'd1);
    check("lock_viol",   32'(viol_cnt), 32'd1);
    check("lock_held",   32'(locked),   32'd1);
    access(1'b0, 2'd0, 8'h00, 1'b0, rd, er, lat);
    check("lock_addr0", 32'(rd), 32'd0);
    check("lock_rderr", 32'(er), 32'd0);

    // Violation counter saturation
    for (int k = 0; k < 253; k++) access(1'b1, 2'd0, 8'h55, 1'b0, rd, er, lat);
    check("viol_254", 32'(viol_cnt), 32'd254);
    for (int k = 0; k < 7; k++) access(1'b1, 2'd0, 8'h55, 1'b0, rd, er, lat);
    check("viol_sat", 32'(viol_cnt), 32'd255);
    check("viol_err", 32'(er),       32'd1);

    // Reset in the middle of CHECK abandons the write
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    cfg_re = 1'b1; cfg_we = 1'b1;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 2'd2; req_wdata = 8'h5A;
    tick();
    req_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("abort_ready",  32'(req_ready), 32'd1);
    check("abort_valid",  32'(rsp_valid), 32'd0);
    check("abort_locked", 32'(locked),    32'd0);
    check("abort_viol",   32'(viol_cnt),  32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("abort_no_rsp", 32'(rsp_valid), 32'd0);
    end
    access(1'b0, 2'd2, 8'h00, 1'b0, rd, er, lat);
    check("abort_addr2", 32'(rd),  32'd0);
    check("abort_rderr", 32'(er),  32'd0);
    check("abort_lat",   32'(lat), 32'd2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
